id_hazard_unit: RTL and testbench



---
 rtl/id_hazard_unit_pkg.sv | 20 ++
 rtl/id_hazard_unit_if.sv | 41 ++++
 rtl/id_hazard_unit_operand_fwd.sv | 33 +++
 rtl/id_hazard_unit.sv | 98 +++++++++
 tb/tb_id_hazard_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/id_hazard_unit_pkg.sv
// Shared types and defaults for the decode-stage operand hazard unit.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package id_hazard_unit_pkg;

   localparam int MAX_LAT_DEF = 7;
   localparam int LAT_W_DEF   = $clog2(MAX_LAT_DEF + 1);

   typedef logic [LAT_W_DEF-1:0] Lat_t;
   typedef logic [4:0]           Reg_addr_t;
   typedef logic [31:0]          Word_t;

   localparam Reg_addr_t REG_ZERO = 5'd0;

   // True for any architectural register that carries real state.
   function automatic logic is_gpr(input Reg_addr_t addr);
      return addr != REG_ZERO;
   endfunction

endpackage

// File: rtl/id_hazard_unit_if.sv
// Bundle between decode, register file, result buses and the hazard unit.
// Latency: n/a (wires only).
// Backpressure: stall_o is the only backpressure, asserted by the slave side.
// Ports: flush/decode instruction fields, NUM_READ read ports with RF data,
// NUM_FWD forwarding sources (0 = youngest), resolved operands, stall, pend_any.
interface id_hazard_unit_if
   import id_hazard_unit_pkg::*;
#(
   parameter int NUM_READ = 2,
   parameter int NUM_FWD  = 2,
   parameter int LAT_W    = LAT_W_DEF
) ();

   logic                        flush_i;
   logic                        id_valid_i;
   logic                        id_wreg_write_i;
   Reg_addr_t                   id_wreg_addr_i;
   logic [LAT_W-1:0]            id_lat_i;
   logic [NUM_READ-1:0]         rd_en_i;
   Reg_addr_t [NUM_READ-1:0]    rd_addr_i;
   Word_t [NUM_READ-1:0]        rf_data_i;
   logic [NUM_FWD-1:0]          fwd_valid_i;
   Reg_addr_t [NUM_FWD-1:0]     fwd_addr_i;
   Word_t [NUM_FWD-1:0]         fwd_data_i;
   Word_t [NUM_READ-1:0]        rd_data_o;
   logic                        stall_o;
   logic                        pend_any_o;

   modport master (
      output flush_i, id_valid_i, id_wreg_write_i, id_wreg_addr_i, id_lat_i,
      output rd_en_i, rd_addr_i, rf_data_i, fwd_valid_i, fwd_addr_i, fwd_data_i,
      input  rd_data_o, stall_o, pend_any_o
   );

   modport slave (
      input  flush_i, id_valid_i, id_wreg_write_i, id_wreg_addr_i, id_lat_i,
      input  rd_en_i, rd_addr_i, rf_data_i, fwd_valid_i, fwd_addr_i, fwd_data_i,
      output rd_data_o, stall_o, pend_any_o
   );

endinterface

// File: rtl/id_hazard_unit_operand_fwd.sv
// Per-read-port operand resolver: priority mux over forwarding sources, RF fallback.
// Latency: combinational, zero cycles.
// Backpressure: none; stalling is decided by the enclosing hazard unit.
// Ports: en_i/addr_i/rf_data_i for the port, fwd_* sources (0 wins), data_o.
module id_hazard_unit_operand_fwd
   import id_hazard_unit_pkg::*;
#(
   parameter int NUM_FWD = 2
) (
   input  logic                    en_i,
   input  Reg_addr_t               addr_i,
   input  Word_t                   rf_data_i,
   input  logic [NUM_FWD-1:0]      fwd_valid_i,
   input  Reg_addr_t [NUM_FWD-1:0] fwd_addr_i,
   input  Word_t [NUM_FWD-1:0]     fwd_data_i,
   output Word_t                   data_o
);

   always_comb begin
      data_o = rf_data_i;
      // Walk oldest to youngest so the youngest match overwrites last.
      for (int f = NUM_FWD - 1; f >= 0; f--) begin
         if (fwd_valid_i[f] && (fwd_addr_i[f] == addr_i)) begin
            data_o = fwd_data_i[f];
         end
      end
      // r0 is hardwired zero; a disabled port yields zero so decode can mux an immediate.
      if (!en_i || !is_gpr(addr_i)) begin
         data_o = '0;
      end
   end

endmodule

// File: rtl/id_hazard_unit.sv
// Decode-stage operand hazard unit: per-GPR countdown scoreboard, RAW/WAW stall, operand forwarding.
// Latency: outputs combinational from registered scoreboard and current inputs; scoreboard updates each edge.
// Backpressure: stall_o holds decode; nothing is recorded while stalled or flushed.
// Ports: clk, rst (async active-low), hz (slave side of id_hazard_unit_if).
module id_hazard_unit
   import id_hazard_unit_pkg::*;
#(
   parameter int NUM_READ = 2,
   parameter int NUM_FWD  = 2,
   parameter int MAX_LAT  = MAX_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   id_hazard_unit_if.slave  hz
);

   localparam int               LAT_W     = $clog2(MAX_LAT + 1);
   localparam logic [LAT_W-1:0] MAX_LAT_V = LAT_W'(MAX_LAT);

   // Entry 0 exists only so any 5-bit address indexes safely; it is held at zero.
   logic [LAT_W-1:0] pend_q [32];
   logic [LAT_W-1:0] pend_d [32];

   logic             raw_hit;
   logic             waw_hit;
   logic             stall;
   logic             issue;
   logic [LAT_W-1:0] lat_clamp;
   Word_t            port_data [NUM_READ];

   always_comb begin
      raw_hit = 1'b0;
      for (int p = 0; p < NUM_READ; p++) begin
         if (hz.rd_en_i[p] && is_gpr(hz.rd_addr_i[p]) && (pend_q[hz.rd_addr_i[p]] != '0)) begin
            raw_hit = 1'b1;
         end
      end
      // A younger write must not land before an older in-flight write to the same register.
      waw_hit = hz.id_valid_i && hz.id_wreg_write_i && is_gpr(hz.id_wreg_addr_i) &&
                (pend_q[hz.id_wreg_addr_i] > hz.id_lat_i);
      stall   = rst && hz.id_valid_i && !hz.flush_i && (raw_hit || waw_hit);
      issue   = hz.id_valid_i && !stall && !hz.flush_i && hz.id_wreg_write_i &&
                is_gpr(hz.id_wreg_addr_i);
      lat_clamp = (hz.id_lat_i > MAX_LAT_V) ? MAX_LAT_V : hz.id_lat_i;
   end

   always_comb begin
      for (int r = 0; r < 32; r++) begin
         pend_d[r] = (pend_q[r] != '0) ? pend_q[r] - 1'b1 : '0;
         if (issue && (hz.id_wreg_addr_i == 5'(r))) begin
            pend_d[r] = lat_clamp;
         end
         if (hz.flush_i || (r == 0)) begin
            pend_d[r] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < 32; r++) begin
            pend_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < 32; r++) begin
            pend_q[r] <= pend_d[r];
         end
      end
   end

   for (genvar p = 0; p < NUM_READ; p++) begin : g_port
      id_hazard_unit_operand_fwd #(
         .NUM_FWD     (NUM_FWD)
      ) u_operand_fwd (
         .en_i        (hz.rd_en_i[p]),
         .addr_i      (hz.rd_addr_i[p]),
         .rf_data_i   (hz.rf_data_i[p]),
         .fwd_valid_i (hz.fwd_valid_i),
         .fwd_addr_i  (hz.fwd_addr_i),
         .fwd_data_i  (hz.fwd_data_i),
         .data_o      (port_data[p])
      );
   end

   always_comb begin
      hz.pend_any_o = 1'b0;
      for (int r = 1; r < 32; r++) begin
         if (pend_q[r] != '0) begin
            hz.pend_any_o = 1'b1;
         end
      end
      hz.stall_o = stall;
      for (int p = 0; p < NUM_READ; p++) begin
         hz.rd_data_o[p] = rst ? port_data[p] : '0;
      end
   end

endmodule

// File: tb/tb_id_hazard_unit.sv
module tb_id_hazard_unit;
   import id_hazard_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   id_hazard_unit_if #(.NUM_READ(2), .NUM_FWD(2), .LAT_W(3)) hz ();

   id_hazard_unit #(.NUM_READ(2), .NUM_FWD(2), .MAX_LAT(6)) dut (
      .clk (clk),
      .rst (rst_n),
      .hz  (hz)
   );

   typedef struct {
      string       name;
      logic        valid;
      logic        wr;
      logic [4:0]  waddr;
      logic [2:0]  lat;
      logic        flush;
      logic [1:0]  en;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [1:0]  fv;
      logic [4:0]  fa0;
      logic [31:0] fd0;
      logic [4:0]  fa1;
      logic [31:0] fd1;
      logic        e_stall;
      logic        e_pend;
      logic [31:0] e_rd0;
      logic [31:0] e_rd1;
   } vec_t;

   typedef struct {
      string       name;
      logic        stall;
      logic        pend;
      logic [31:0] rd0;
      logic [31:0] rd1;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   function automatic logic [31:0] rf_val(input int p, input logic [4:0] a);
      return {8'hC0 + 8'(p), 19'd0, a};
   endfunction

   function automatic vec_t mk(input string n, input logic v, input logic wr,
                               input logic [4:0] wa, input logic [2:0] lat, input logic fl,
                               input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1,
                               input logic [1:0] fv, input logic [4:0] fa0, input logic [31:0] fd0,
                               input logic [4:0] fa1, input logic [31:0] fd1,
                               input logic es, input logic ep,
                               input logic [31:0] er0, input logic [31:0] er1);
      vec_t t;
      t.name = n; t.valid = v; t.wr = wr; t.waddr = wa; t.lat = lat; t.flush = fl;
      t.en = en; t.a0 = a0; t.a1 = a1; t.fv = fv; t.fa0 = fa0; t.fd0 = fd0;
      t.fa1 = fa1; t.fd1 = fd1; t.e_stall = es; t.e_pend = ep; t.e_rd0 = er0; t.e_rd1 = er1;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      hz.flush_i = 1'b0; hz.id_valid_i = 1'b0; hz.id_wreg_write_i = 1'b0;
      hz.id_wreg_addr_i = '0; hz.id_lat_i = '0; hz.rd_en_i = '0; hz.rd_addr_i = '0;
      hz.rf_data_i = '0; hz.fwd_valid_i = '0; hz.fwd_addr_i = '0; hz.fwd_data_i = '0;
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      hz.flush_i = v.flush; hz.id_valid_i = v.valid; hz.id_wreg_write_i = v.wr;
      hz.id_wreg_addr_i = v.waddr; hz.id_lat_i = v.lat; hz.rd_en_i = v.en;
      hz.rd_addr_i[0] = v.a0; hz.rd_addr_i[1] = v.a1;
      hz.rf_data_i[0] = rf_val(0, v.a0); hz.rf_data_i[1] = rf_val(1, v.a1);
      hz.fwd_valid_i = v.fv;
      hz.fwd_addr_i[0] = v.fa0; hz.fwd_addr_i[1] = v.fa1;
      hz.fwd_data_i[0] = v.fd0; hz.fwd_data_i[1] = v.fd1;
      e.name = v.name; e.stall = v.e_stall; e.pend = v.e_pend; e.rd0 = v.e_rd0; e.rd1 = v.e_rd1;
      sb.push_back(e);
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         check({e.name, ".stall"}, 32'(hz.stall_o), 32'(e.stall));
         check({e.name, ".pend_any"}, 32'(hz.pend_any_o), 32'(e.pend));
         check({e.name, ".rd0"}, hz.rd_data_o[0], e.rd0);
         check({e.name, ".rd1"}, hz.rd_data_o[1], e.rd1);
      end
   endtask

   task automatic step(input vec_t v);
      drive(v);
      @(negedge clk);
      check_out();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Stimulus table, one row per decode cycle.
      tbl.push_back(mk("idle",       0,0,5'd0,3'd0,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      tbl.push_back(mk("rf_read",    1,0,5'd0,3'd0,0, 2'b11,5'd4,5'd0, 2'b01,5'd0,32'hDEADBEEF,5'd7,32'h0, 0,0,rf_val(0,5'd4),32'h0));
      tbl.push_back(mk("alu_issue",  1,1,5'd3,3'd0,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      tbl.push_back(mk("alu_use",    1,0,5'd0,3'd0,0, 2'b01,5'd3,5'd0, 2'b01,5'd3,32'h1234,5'd0,32'h0, 0,0,32'h1234,32'h0));
      tbl.push_back(mk("load_issue", 1,1,5'd5,3'd1,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      tbl.push_back(mk("load_stall", 1,0,5'd0,3'd0,0, 2'b01,5'd5,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 1,1,rf_val(0,5'd5),32'h0));
      tbl.push_back(mk("load_go",    1,0,5'd0,3'd0,0, 2'b01,5'd5,5'd0, 2'b01,5'd5,32'h5555,5'd0,32'h0, 0,0,32'h5555,32'h0));
      tbl.push_back(mk("div_issue",  1,1,5'd8,3'd6,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      for (int i = 0; i < 6; i++)
         tbl.push_back(mk("div_stall", 1,0,5'd0,3'd0,0, 2'b10,5'd0,5'd8, 2'b00,5'd0,32'h0,5'd0,32'h0, 1,1,32'h0,rf_val(1,5'd8)));
      tbl.push_back(mk("div_go",     1,0,5'd0,3'd0,0, 2'b11,5'd8,5'd8, 2'b11,5'd8,32'hAAAA0001,5'd8,32'hBBBB0002, 0,0,32'hAAAA0001,32'hAAAA0001));
      tbl.push_back(mk("fwd_older",  1,0,5'd0,3'd0,0, 2'b01,5'd6,5'd6, 2'b11,5'd7,32'h77777777,5'd6,32'hBBBB0006, 0,0,32'hBBBB0006,32'h0));
      tbl.push_back(mk("waw_issue",  1,1,5'd9,3'd5,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      tbl.push_back(mk("waw_gap",    0,0,5'd0,3'd0,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,1,32'h0,32'h0));
      tbl.push_back(mk("waw_stall",  1,1,5'd9,3'd0,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 1,1,32'h0,32'h0));
      tbl.push_back(mk("flush",      1,1,5'd10,3'd3,1, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,1,32'h0,32'h0));
      tbl.push_back(mk("post_flush", 1,0,5'd0,3'd0,0, 2'b11,5'd10,5'd9, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,rf_val(0,5'd10),rf_val(1,5'd9)));
      tbl.push_back(mk("r0_issue",   1,1,5'd0,3'd5,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      tbl.push_back(mk("r0_after",   0,0,5'd0,3'd0,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      tbl.push_back(mk("clamp_issue",1,1,5'd2,3'd7,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      for (int i = 0; i < 6; i++)
         tbl.push_back(mk("clamp_stall", 1,0,5'd0,3'd0,0, 2'b01,5'd2,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 1,1,rf_val(0,5'd2),32'h0));
      tbl.push_back(mk("clamp_go",   1,0,5'd0,3'd0,0, 2'b01,5'd2,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,rf_val(0,5'd2),32'h0));
      tbl.push_back(mk("ovr_a",      1,1,5'd11,3'd5,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      tbl.push_back(mk("ovr_b",      1,1,5'd11,3'd6,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,1,32'h0,32'h0));
      for (int i = 0; i < 6; i++)
         tbl.push_back(mk("ovr_stall", 1,0,5'd0,3'd0,0, 2'b01,5'd11,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 1,1,rf_val(0,5'd11),32'h0));
      tbl.push_back(mk("ovr_go",     1,0,5'd0,3'd0,0, 2'b01,5'd11,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,rf_val(0,5'd11),32'h0));

      // Reset held low with random inputs.
      rst_n = 1'b0;
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         hz.flush_i = 1'($urandom()); hz.id_valid_i = 1'($urandom());
         hz.id_wreg_write_i = 1'($urandom()); hz.id_wreg_addr_i = 5'($urandom());
         hz.id_lat_i = 3'($urandom()); hz.rd_en_i = 2'($urandom());
         hz.rd_addr_i = 10'($urandom()); hz.rf_data_i = {$urandom(), $urandom()};
         hz.fwd_valid_i = 2'($urandom()); hz.fwd_addr_i = 10'($urandom());
         hz.fwd_data_i = {$urandom(), $urandom()};
         @(negedge clk);
         check("reset.stall", 32'(hz.stall_o), 32'h0);
         check("reset.rd0", hz.rd_data_o[0], 32'h0);
         check("reset.rd1", hz.rd_data_o[1], 32'h0);
      end
      @(posedge clk);
      #1;
      idle_inputs();
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset.pend_any", 32'(hz.pend_any_o), 32'h0);
      @(posedge clk);
      #1;

      foreach (tbl[i]) step(tbl[i]);

      // Reset asserted mid-operation with a long result in flight.
      step(mk("mid_issue", 1,1,5'd12,3'd6,0, 2'b00,5'd0,5'd0, 2'b00,5'd0,32'h0,5'd0,32'h0, 0,0,32'h0,32'h0));
      idle_inputs();
      hz.id_valid_i = 1'b1; hz.rd_en_i = 2'b01; hz.rd_addr_i[0] = 5'd12;
      hz.rf_data_i[0] = rf_val(0, 5'd12);
      #2;
      check("mid.stall_before", 32'(hz.stall_o), 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid.stall_in_reset", 32'(hz.stall_o), 32'h0);
      check("mid.pend_in_reset", 32'(hz.pend_any_o), 32'h0);
      check("mid.rd0_in_reset", hz.rd_data_o[0], 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("mid.stall_after", 32'(hz.stall_o), 32'h0);
      check("mid.pend_after", 32'(hz.pend_any_o), 32'h0);
      check("mid.rd0_after", hz.rd_data_o[0], rf_val(0, 5'd12));

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
